// File: rtl/traffic_light_monitor.sv
// Passive safety/sequence monitor for the four traffic-light lamp buses; latches the first fault.
// Define TLM_DWELL_CHECK_EN to add per-phase dwell-time checks (EARLY/OVERSTAY) and the DWELLn parameters.
module traffic_light_monitor
`ifdef TLM_DWELL_CHECK_EN
#(
  parameter int unsigned DWELL1 = 8,
  parameter int unsigned DWELL2 = 3,
  parameter int unsigned DWELL3 = 6,
  parameter int unsigned DWELL4 = 3,
  parameter int unsigned DWELL5 = 4,
  parameter int unsigned DWELL6 = 3
)
`endif
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_S,
  input  logic       clr_fault,
  output logic [2:0] phase,
  output logic       in_sync,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [2:0] fault_phase,
  output logic [7:0] cycle_count
);

  localparam int unsigned CYC_W = 8;

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_ILLEGAL  = 3'd1;
  localparam logic [2:0] FC_SEQUENCE = 3'd4;
  localparam logic [2:0] FC_CONFLICT = 3'd5;

`ifdef TLM_DWELL_CHECK_EN
  localparam int unsigned DWELL_W = 5;
  localparam logic [2:0] FC_EARLY    = 3'd2;
  localparam logic [2:0] FC_OVERSTAY = 3'd3;
`endif

  logic [1:0]       state_q, state_d;
  logic [2:0]       cur_q, cur_d;
  logic [2:0]       phase_q, phase_d;
  logic             in_sync_q, in_sync_d;
  logic             fault_q, fault_d;
  logic [2:0]       fault_code_q, fault_code_d;
  logic [2:0]       fault_phase_q, fault_phase_d;
  logic [CYC_W-1:0] cycle_q, cycle_d;
`ifdef TLM_DWELL_CHECK_EN
  logic [DWELL_W-1:0] dwell_q, dwell_d;
`endif

  logic [2:0] samp_phase_c;
  logic       conflict_c;
  logic       illegal_c;
  logic [2:0] next_cur_c;
  logic [2:0] code_c;
  logic       advance_c;

  function automatic logic is_onehot3(input logic [2:0] b);
    return (b == LAMP_G) || (b == LAMP_Y) || (b == LAMP_R);
  endfunction

`ifdef TLM_DWELL_CHECK_EN
  function automatic logic [DWELL_W-1:0] dwell_limit(input logic [2:0] p);
    logic [DWELL_W-1:0] lim;
    case (p)
      3'd1:    lim = DWELL_W'(DWELL1);
      3'd2:    lim = DWELL_W'(DWELL2);
      3'd3:    lim = DWELL_W'(DWELL3);
      3'd4:    lim = DWELL_W'(DWELL4);
      3'd5:    lim = DWELL_W'(DWELL5);
      default: lim = DWELL_W'(DWELL6);
    endcase
    return lim;
  endfunction
`endif

  // Lamp pattern (M1/M2/MT/S) to phase number; 0 for anything unrecognised
  always_comb begin
    case ({light_M1, light_M2, light_MT, light_S})
      {LAMP_G, LAMP_G, LAMP_R, LAMP_R}: samp_phase_c = 3'd1;
      {LAMP_G, LAMP_Y, LAMP_R, LAMP_R}: samp_phase_c = 3'd2;
      {LAMP_G, LAMP_R, LAMP_G, LAMP_R}: samp_phase_c = 3'd3;
      {LAMP_Y, LAMP_R, LAMP_Y, LAMP_R}: samp_phase_c = 3'd4;
      {LAMP_R, LAMP_R, LAMP_R, LAMP_G}: samp_phase_c = 3'd5;
      {LAMP_R, LAMP_R, LAMP_R, LAMP_Y}: samp_phase_c = 3'd6;
      default:                          samp_phase_c = 3'd0;
    endcase
  end

  // Any non-red lamp (including a malformed bus) counts as "not red" for conflicts
  assign conflict_c = ((light_S != LAMP_R) &&
                       ((light_M1 != LAMP_R) || (light_M2 != LAMP_R) || (light_MT != LAMP_R))) ||
                      ((light_MT != LAMP_R) && (light_M2 != LAMP_R));

  assign illegal_c = !(is_onehot3(light_M1) && is_onehot3(light_M2) &&
                       is_onehot3(light_MT) && is_onehot3(light_S)) ||
                     (samp_phase_c == 3'd0);

  assign next_cur_c = (cur_q == 3'd6) ? 3'd1 : cur_q + 3'd1;

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    phase_d       = samp_phase_c;
    in_sync_d     = in_sync_q;
    fault_d       = fault_q;
    fault_code_d  = fault_code_q;
    fault_phase_d = fault_phase_q;
    cycle_d       = cycle_q;
    code_c        = FC_NONE;
    advance_c     = 1'b0;
`ifdef TLM_DWELL_CHECK_EN
    dwell_d       = dwell_q;
`endif

    case (state_q)
      ST_SYNC: begin
        if (conflict_c) begin
          code_c = FC_CONFLICT;
        end else if (illegal_c) begin
          code_c = FC_ILLEGAL;
        end else if (samp_phase_c == 3'd1) begin
          state_d   = ST_TRACK;
          cur_d     = 3'd1;
          in_sync_d = 1'b1;
`ifdef TLM_DWELL_CHECK_EN
          dwell_d   = DWELL_W'(1);
`endif
        end
      end

      ST_TRACK: begin
        if (conflict_c) begin
          code_c = FC_CONFLICT;
        end else if (illegal_c) begin
          code_c = FC_ILLEGAL;
        end else if (samp_phase_c == cur_q) begin
`ifdef TLM_DWELL_CHECK_EN
          dwell_d = (dwell_q == '1) ? dwell_q : dwell_q + DWELL_W'(1);
          if (dwell_d > dwell_limit(cur_q)) begin
            code_c = FC_OVERSTAY;
          end
`endif
        end else if (samp_phase_c == next_cur_c) begin
          advance_c = 1'b1;
`ifdef TLM_DWELL_CHECK_EN
          if (dwell_q != dwell_limit(cur_q)) begin
            advance_c = 1'b0;
            code_c    = FC_EARLY;
          end
`endif
          if (advance_c) begin
            cur_d = next_cur_c;
`ifdef TLM_DWELL_CHECK_EN
            dwell_d = DWELL_W'(1);
`endif
            if (next_cur_c == 3'd1) begin
              cycle_d = cycle_q + CYC_W'(1);
            end
          end
        end else begin
          code_c = FC_SEQUENCE;
        end
      end

      ST_FAULT: begin
        if (clr_fault) begin
          state_d       = ST_SYNC;
          cur_d         = 3'd0;
          fault_d       = 1'b0;
          fault_code_d  = FC_NONE;
          fault_phase_d = 3'd0;
`ifdef TLM_DWELL_CHECK_EN
          dwell_d       = '0;
`endif
        end
      end

      default: begin
        state_d = ST_SYNC;
        cur_d   = 3'd0;
      end
    endcase

    // cur_q is 0 while in SYNC, so a SYNC fault records phase 0
    if (code_c != FC_NONE) begin
      state_d       = ST_FAULT;
      fault_d       = 1'b1;
      fault_code_d  = code_c;
      fault_phase_d = cur_q;
      in_sync_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_SYNC;
      cur_q         <= 3'd0;
      phase_q       <= 3'd0;
      in_sync_q     <= 1'b0;
      fault_q       <= 1'b0;
      fault_code_q  <= FC_NONE;
      fault_phase_q <= 3'd0;
      cycle_q       <= '0;
`ifdef TLM_DWELL_CHECK_EN
      dwell_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      phase_q       <= phase_d;
      in_sync_q     <= in_sync_d;
      fault_q       <= fault_d;
      fault_code_q  <= fault_code_d;
      fault_phase_q <= fault_phase_d;
      cycle_q       <= cycle_d;
`ifdef TLM_DWELL_CHECK_EN
      dwell_q       <= dwell_d;
`endif
    end
  end

  assign phase       = phase_q;
  assign in_sync     = in_sync_q;
  assign fault       = fault_q;
  assign fault_code  = fault_code_q;
  assign fault_phase = fault_phase_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: vector table plus hand-written multi-cycle sequences.
module tb_traffic_light_monitor;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic       clk;
  logic       rst;
  logic [2:0] light_M1, light_M2, light_MT, light_S;
  logic       clr_fault;
  logic [2:0] phase;
  logic       in_sync;
  logic       fault;
  logic [2:0] fault_code;
  logic [2:0] fault_phase;
  logic [7:0] cycle_count;

  traffic_light_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .light_M1    (light_M1),
    .light_M2    (light_M2),
    .light_MT    (light_MT),
    .light_S     (light_S),
    .clr_fault   (clr_fault),
    .phase       (phase),
    .in_sync     (in_sync),
    .fault       (fault),
    .fault_code  (fault_code),
    .fault_phase (fault_phase),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [11:0] pat;
    logic        clr;
    logic [18:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [18:0] sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [11:0] pat(input int p);
    logic [11:0] v;
    case (p)
      1:       v = {G, G, R, R};
      2:       v = {G, Y, R, R};
      3:       v = {G, R, G, R};
      4:       v = {Y, R, Y, R};
      5:       v = {R, R, R, G};
      6:       v = {R, R, R, Y};
      default: v = {R, R, R, R};
    endcase
    return v;
  endfunction

  function automatic int dw(input int p);
    int d;
    case (p)
      1: d = 8;
      2: d = 3;
      3: d = 6;
      4: d = 3;
      5: d = 4;
      default: d = 3;
    endcase
    return d;
  endfunction

  // Expected output word: {phase, in_sync, fault, fault_code, fault_phase, cycle_count}
  function automatic logic [18:0] ex(input int ph, input int sy, input int fl,
                                     input int cd, input int fp, input int cy);
    return {3'(ph), 1'(sy), 1'(fl), 3'(cd), 3'(fp), 8'(cy)};
  endfunction

  task automatic check(input string nm, input logic [18:0] e);
    logic [18:0] got;
    got = {phase, in_sync, fault, fault_code, fault_phase, cycle_count};
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s: got ph=%0d sync=%0d flt=%0d code=%0d fph=%0d cyc=%0d, want ph=%0d sync=%0d flt=%0d code=%0d fph=%0d cyc=%0d",
               nm, got[18:16], got[15], got[14], got[13:11], got[10:8], got[7:0],
               e[18:16], e[15], e[14], e[13:11], e[10:8], e[7:0]);
    end
  endtask

  task automatic drive(input logic [11:0] p, input logic clr);
    {light_M1, light_M2, light_MT, light_S} = p;
    clr_fault = clr;
  endtask

  // One sample: drive at negedge, push expectation, compare just after the sampling edge
  task automatic step(input string nm, input logic [11:0] p, input logic clr,
                      input bit chk, input logic [18:0] e);
    @(negedge clk);
    drive(p, clr);
    if (chk) sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (chk) check(nm, sb_q.pop_front());
  endtask

  task automatic add(input string nm, input logic [11:0] p, input logic clr, input logic [18:0] e);
    vec_t v;
    v.nm = nm; v.pat = p; v.clr = clr; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic add_run(input string nm, input int ph, input int n, input int cy);
    for (int i = 0; i < n; i++) add(nm, pat(ph), 1'b0, ex(ph, 1, 0, 0, 0, cy));
  endtask

  task automatic apply_vecs();
    foreach (vecs[i]) step(vecs[i].nm, vecs[i].pat, vecs[i].clr, 1'b1, vecs[i].exp);
    vecs.delete();
  endtask

  // Reset with a harmless idle pattern (legal non-P1 keeps the monitor in SYNC)
  task automatic do_reset();
    @(negedge clk);
    drive(pat(5), 1'b0);
    rst = 1'b1;
    #1;
    check("reset", ex(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cy;
    rst = 1'b1;
    drive(pat(5), 1'b0);

    // Two full controller cycles plus one sample; a stray clr_fault while tracking
    do_reset();
    cy = 0;
    for (int c = 0; c < 2; c++) begin
      for (int p = 1; p <= 6; p++) begin
        if (c > 0 && p == 1) cy++;
        for (int i = 0; i < dw(p); i++)
          add("ctrl_run", pat(p), (c == 0 && p == 2 && i == 1), ex(p, 1, 0, 0, 0, cy));
      end
    end
    add("ctrl_end", pat(1), 1'b0, ex(1, 1, 0, 0, 0, 2));
    apply_vecs();

    // Conflict while tracking, hold in FAULT, clear, relock
    do_reset();
    add_run("p1", 1, 8, 0);
    add("conflict", {G, G, R, G}, 1'b0, ex(0, 0, 1, 5, 1, 0));
    add("fault_hold", pat(5), 1'b0, ex(5, 0, 1, 5, 1, 0));
    add("clr", pat(1), 1'b1, ex(1, 0, 0, 0, 0, 0));
    add("relock", pat(1), 1'b0, ex(1, 1, 0, 0, 0, 0));
    apply_vecs();

    // Conflict beats illegal, raised in SYNC
    do_reset();
    add("prio", {G, G, G, 3'b000}, 1'b0, ex(0, 0, 1, 5, 0, 0));
    apply_vecs();

    // Illegal patterns: in SYNC, M2 all-zero and M2 two-hot while tracking
    do_reset();
    add("sync_illegal", {R, R, R, R}, 1'b0, ex(0, 0, 1, 1, 0, 0));
    add("clr1", pat(1), 1'b1, ex(1, 0, 0, 0, 0, 0));
    add_run("p1", 1, 3, 0);
    add("m2_zero", {G, 3'b000, R, R}, 1'b0, ex(0, 0, 1, 1, 1, 0));
    add("clr2", pat(2), 1'b1, ex(2, 0, 0, 0, 0, 0));
    add_run("p1", 1, 1, 0);
    add("m2_011", {G, 3'b011, R, R}, 1'b0, ex(0, 0, 1, 1, 1, 0));
    apply_vecs();

    // P3 left one sample early
    do_reset();
    add_run("p1", 1, 8, 0);
    add_run("p2", 2, 3, 0);
    add_run("p3", 3, 5, 0);
`ifdef TLM_DWELL_CHECK_EN
    add("early", pat(4), 1'b0, ex(4, 0, 1, 2, 3, 0));
`else
    add("early", pat(4), 1'b0, ex(4, 1, 0, 0, 0, 0));
`endif
    apply_vecs();

    // P5 held one sample too long
    do_reset();
    add_run("p1", 1, 8, 0);
    add_run("p2", 2, 3, 0);
    add_run("p3", 3, 6, 0);
    add_run("p4", 4, 3, 0);
    add_run("p5", 5, 4, 0);
`ifdef TLM_DWELL_CHECK_EN
    add("overstay", pat(5), 1'b0, ex(5, 0, 1, 3, 5, 0));
`else
    add("overstay", pat(5), 1'b0, ex(5, 1, 0, 0, 0, 0));
`endif
    apply_vecs();

    // Out-of-order phase, clear, relock, then asynchronous reset mid-P3
    do_reset();
    add_run("p1", 1, 8, 0);
    add("sequence", pat(3), 1'b0, ex(3, 0, 1, 4, 1, 0));
    add("seq_clr", pat(3), 1'b1, ex(3, 0, 0, 0, 0, 0));
    add("sync_p3", pat(3), 1'b0, ex(3, 0, 0, 0, 0, 0));
    add("relock", pat(1), 1'b0, ex(1, 1, 0, 0, 0, 0));
    add_run("p1", 1, 7, 0);
    add_run("p2", 2, 3, 0);
    add_run("p3", 3, 2, 0);
    apply_vecs();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", ex(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(pat(5), 1'b0);
    rst = 1'b0;

    // cycle_count wrap 255 -> 0 over 256 completed cycles
    do_reset();
    for (int c = 0; c <= 256; c++) begin
      for (int p = 1; p <= 6; p++) begin
        for (int i = 0; i < dw(p); i++) begin
          step("cycle_wrap", pat(p), 1'b0,
               (p == 1 && i == 0 && (c == 1 || c == 255 || c == 256)),
               ex(1, 1, 0, 0, 0, c % 256));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
